// File: rtl/percep_pkg.sv
// -----------------------------------------------------------------------------
// percep_pkg
// Shared definitions for the perceptron datapath (MAC/accumulator and the
// later activation stage): default fixed-point format, its saturation bounds,
// the accumulator FSM state type and a constant-evaluable ceil(log2) helper.
// -----------------------------------------------------------------------------
package percep_pkg;

    // Default data format: signed Q8.8
    localparam int FP_WIDTH_DEF  = 16;
    localparam int FRAC_BITS_DEF = 8;

    // Representable bounds of the default format
    localparam logic [FP_WIDTH_DEF-1:0] FP_MAX = {1'b0, {(FP_WIDTH_DEF-1){1'b1}}};
    localparam logic [FP_WIDTH_DEF-1:0] FP_MIN = {1'b1, {(FP_WIDTH_DEF-1){1'b0}}};

    // Accumulator FSM: IDLE = no partial sum held, ACC = mid-sample
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // ceil(log2(v)); clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/percep_sat.sv
// -----------------------------------------------------------------------------
// percep_sat
// Combinational signed saturator from a wide two's-complement value down to
// OUT_W bits. Values above 2^(OUT_W-1)-1 or below -2^(OUT_W-1) are clipped to
// the nearest bound and o_clip is raised.
// Ports:
//   i_val  [IN_W-1:0]   wide signed input
//   o_val  [OUT_W-1:0]  saturated result
//   o_clip              1 when o_val was clipped
// -----------------------------------------------------------------------------
module percep_sat #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic        [OUT_W-1:0] o_val,
    output logic                    o_clip
);

    // Output bounds, sign-extended to the input width for direct comparison
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clip against the bounds, otherwise pass the low bits through
    always_comb begin
        o_val  = i_val[OUT_W-1:0];
        o_clip = 1'b0;
        if (i_val > SAT_MAX) begin
            o_val  = {1'b0, {(OUT_W-1){1'b1}}};
            o_clip = 1'b1;
        end else if (i_val < SAT_MIN) begin
            o_val  = {1'b1, {(OUT_W-1){1'b0}}};
            o_clip = 1'b1;
        end else begin
            o_val  = i_val[OUT_W-1:0];
            o_clip = 1'b0;
        end
    end

endmodule

// File: rtl/percep_mac_acc.sv
// -----------------------------------------------------------------------------
// percep_mac_acc
// Two-stage signed fixed-point multiply-accumulate. Stage 1 registers the
// rescaled product x_in*w_in; stage 2 adds N_FEAT products plus a bias and
// emits one saturated result per sample. The stall input freezes every
// register so this block moves in lockstep with the x/w pipeline register.
// Ports:
//   clk       clock, posedge
//   rst       synchronous active-high reset (dominates stall)
//   stall     hold all registers this cycle
//   in_valid  x_in/w_in carry a valid pair
//   x_in      feature  [FP_WIDTH-1:0]
//   w_in      weight   [FP_WIDTH-1:0]
//   bias      bias added at the first product of a sample
//   y_out     saturated dot product, held until the next result
//   y_valid   result strobe
//   sat_flag  y_out was clipped
//   busy      a partial sum is held
// -----------------------------------------------------------------------------
module percep_mac_acc
    import percep_pkg::*;
#(
    parameter int FP_WIDTH  = FP_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int N_FEAT    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                in_valid,
    input  logic [FP_WIDTH-1:0] x_in,
    input  logic [FP_WIDTH-1:0] w_in,
    input  logic [FP_WIDTH-1:0] bias,
    output logic [FP_WIDTH-1:0] y_out,
    output logic                y_valid,
    output logic                sat_flag,
    output logic                busy
);

    // Wide enough that N_FEAT products plus bias can never wrap
    localparam int ACC_WIDTH = 2*FP_WIDTH - FRAC_BITS + clog2(N_FEAT + 1);
    localparam int CNT_W     = (N_FEAT > 1) ? clog2(N_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

    logic signed [2*FP_WIDTH-1:0] w_x_ext;
    logic signed [2*FP_WIDTH-1:0] w_w_ext;
    logic signed [2*FP_WIDTH-1:0] w_prod;
    logic signed [2*FP_WIDTH-1:0] w_prod_shift;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic        [FP_WIDTH-1:0]   w_sat_val;
    logic                         w_sat_clip;
    logic                         w_is_last;

    logic signed [ACC_WIDTH-1:0]  r_p;
    logic                         r_p_valid;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [CNT_W-1:0]      r_cnt;
    logic        [FP_WIDTH-1:0]   r_y_out;
    logic                         r_y_valid;
    logic                         r_sat_flag;
    state_t                       r_state;

    // Operands are sign-extended to full product width so the multiply is exact
    assign w_x_ext      = {{FP_WIDTH{x_in[FP_WIDTH-1]}}, x_in};
    assign w_w_ext      = {{FP_WIDTH{w_in[FP_WIDTH-1]}}, w_in};
    assign w_prod       = w_x_ext * w_w_ext;
    // Arithmetic shift rounds toward -inf (e.g. raw -1 stays -1)
    assign w_prod_shift = w_prod >>> FRAC_BITS;
    assign w_prod_ext   = ACC_WIDTH'(w_prod_shift);
    assign w_bias_ext   = ACC_WIDTH'($signed(bias));
    assign w_is_last    = (r_cnt == LAST_IDX);

    // Next accumulator value: bias seeds the first product of each sample
    always_comb begin
        if (r_cnt == {CNT_W{1'b0}}) begin
            w_acc_next = w_bias_ext + r_p;
        end else begin
            w_acc_next = r_acc + r_p;
        end
    end

    percep_sat #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (FP_WIDTH)
    ) u_sat (
        .i_val  (w_acc_next),
        .o_val  (w_sat_val),
        .o_clip (w_sat_clip)
    );

    // Multiply stage, accumulate stage and FSM; stall freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p        <= {ACC_WIDTH{1'b0}};
            r_p_valid  <= 1'b0;
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_y_out    <= {FP_WIDTH{1'b0}};
            r_y_valid  <= 1'b0;
            r_sat_flag <= 1'b0;
            r_state    <= IDLE;
        end else if (!stall) begin
            r_p       <= w_prod_ext;
            r_p_valid <= in_valid;
            r_y_valid <= 1'b0;
            if (r_p_valid) begin
                r_acc <= w_acc_next;
                if (w_is_last) begin
                    r_cnt      <= {CNT_W{1'b0}};
                    r_y_out    <= w_sat_val;
                    r_sat_flag <= w_sat_clip;
                    r_y_valid  <= 1'b1;
                    r_state    <= IDLE;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= ACC;
                end
            end
        end
    end

    assign y_out    = r_y_out;
    assign y_valid  = r_y_valid;
    assign sat_flag = r_sat_flag;
    assign busy     = (r_state == ACC);

endmodule
